// File: rtl/aes_key_expand_seq_pkg.sv
// Shared types and helpers for the iterative AES key schedule: key-length
// encodings, Nk/Nr lookup, RotWord, xtime and GF(2^8) arithmetic for the S-box.
package aes_key_expand_seq_pkg;

    typedef enum logic [1:0] {
        KEY_128 = 2'b00,
        KEY_192 = 2'b01,
        KEY_256 = 2'b10,
        KEY_BAD = 2'b11
    } key_len_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
        logic       legal;
    } key_cfg_t;

    // Largest schedule (AES-256): 4*(14+1) words.
    localparam int MAX_WORDS = 60;

    function automatic key_cfg_t key_cfg(input logic [1:0] key_len);
        key_cfg_t c;
        case (key_len)
            KEY_128: c = '{nk: 4'd4, nr: 4'd10, legal: 1'b1};
            KEY_192: c = '{nk: 4'd6, nr: 4'd12, legal: 1'b1};
            KEY_256: c = '{nk: 4'd8, nr: 4'd14, legal: 1'b1};
            default: c = '{nk: 4'd0, nr: 4'd0, legal: 1'b0};
        endcase
        return c;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] t);
        return {t[23:0], t[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Request/status/read-port bundle between key-load logic, round engine and the
// key schedule. Optional KEYEXP_DEC_ORDER_EN adds rk_rev (decryption-order reads).
interface aes_key_expand_seq_if #(
    parameter int MAX_NK = 8
);
    logic                  start;
    logic [1:0]            key_len;
    logic [32*MAX_NK-1:0]  key;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  key_ready;
    logic [3:0]            rk_idx;
    logic [127:0]          rk_out;
    logic                  rk_valid;
`ifdef KEYEXP_DEC_ORDER_EN
    logic                  rk_rev;
`endif

    modport master (
`ifdef KEYEXP_DEC_ORDER_EN
        output rk_rev,
`endif
        output start, key_len, key, rk_idx,
        input  busy, done, err, key_ready, rk_out, rk_valid
    );

    modport slave (
`ifdef KEYEXP_DEC_ORDER_EN
        input  rk_rev,
`endif
        input  start, key_len, key, rk_idx,
        output busy, done, err, key_ready, rk_out, rk_valid
    );

endinterface

// File: rtl/aes_key_expand_seq_sbox.sv
// AES forward S-box for one byte: GF(2^8) inverse followed by the affine map.
module aes_key_expand_seq_sbox
    import aes_key_expand_seq_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        y   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock into a
// 4*(MAX_NR+1)-word store, with a registered 128-bit round-key read port.
// Build option: KEYEXP_DEC_ORDER_EN enables rk_rev (reads round Nr-rk_idx).
module aes_key_expand_seq
    import aes_key_expand_seq_pkg::*;
#(
    parameter int MAX_NK = 8,
    parameter int MAX_NR = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_expand_seq_if.slave bus
);

    localparam int DEPTH = 4 * (MAX_NR + 1);
    localparam int IW    = $clog2(DEPTH);

    state_e          state_q;
    state_e          state_d;
    key_cfg_t        start_cfg;
    logic            load;
    logic            bad;
    logic            step;
    logic            last;

    logic [3:0]      nk_q;
    logic [3:0]      nr_q;
    logic [IW-1:0]   i_q;
    logic [2:0]      j_q;
    logic [7:0]      rcon_q;
    logic [IW-1:0]   last_idx;

    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            key_ready_q;
    logic [127:0]    rk_out_q;
    logic            rk_valid_q;

    logic [31:0]     w [DEPTH];
    logic [31:0]     w_prev;
    logic [31:0]     w_back;
    logic [31:0]     sbox_in;
    logic [31:0]     sbox_out;
    logic [31:0]     temp;
    logic [31:0]     w_new;

    logic [3:0]      rd_round;
    logic [IW-1:0]   rd_base;
    logic            rd_hit;

    assign start_cfg = key_cfg(bus.key_len);
    assign last_idx  = IW'(4 * (int'(nr_q) + 1) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        bad     = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (start_cfg.legal) begin
                        load    = 1'b1;
                        state_d = ST_EXPAND;
                    end else begin
                        bad = 1'b1;
                    end
                end
            end
            ST_EXPAND: begin
                step = 1'b1;
                if (i_q == last_idx) begin
                    last    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nk_q        <= '0;
            nr_q        <= '0;
            i_q         <= '0;
            j_q         <= '0;
            rcon_q      <= 8'h01;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            done_q <= last;
            err_q  <= bad;
            if (load) begin
                nk_q        <= start_cfg.nk;
                nr_q        <= start_cfg.nr;
                i_q         <= IW'(start_cfg.nk);
                j_q         <= '0;
                rcon_q      <= 8'h01;
                busy_q      <= 1'b1;
                key_ready_q <= 1'b0;
            end else if (bad) begin
                key_ready_q <= 1'b0;
            end else if (step) begin
                i_q <= i_q + IW'(1);
                j_q <= ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
                if (last) begin
                    busy_q      <= 1'b0;
                    key_ready_q <= 1'b1;
                end
            end
        end
    end

    // One shared S-box bank; j==0 feeds it the rotated word, Nk=8/j==4 the plain word.
    always_comb begin
        w_prev  = w[i_q - IW'(1)];
        w_back  = w[i_q - IW'(nk_q)];
        sbox_in = (j_q == 3'd0) ? rot_word(w_prev) : w_prev;
        if (j_q == 3'd0)                         temp = sbox_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && j_q == 3'd4)    temp = sbox_out;
        else                                     temp = w_prev;
        w_new = w_back ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_key_expand_seq_sbox u_sbox (
            .a (sbox_in[8*b +: 8]),
            .y (sbox_out[8*b +: 8])
        );
    end

    // NOTE: the word store has no reset; key_ready gates every read, so stale contents are never exposed.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < MAX_NK; k++) begin
                if (k < int'(start_cfg.nk)) w[k] <= bus.key[k*32 +: 32];
            end
        end else if (step) begin
            w[i_q] <= w_new;
        end
    end

    always_comb begin
`ifdef KEYEXP_DEC_ORDER_EN
        rd_round = bus.rk_rev ? (nr_q - bus.rk_idx) : bus.rk_idx;
`else
        rd_round = bus.rk_idx;
`endif
        rd_base = IW'({rd_round, 2'b00});
        rd_hit  = key_ready_q && (bus.rk_idx <= nr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out_q   <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            rk_valid_q <= rd_hit;
            rk_out_q   <= rd_hit ? {w[rd_base + IW'(3)], w[rd_base + IW'(2)],
                                    w[rd_base + IW'(1)], w[rd_base]} : '0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.key_ready = key_ready_q;
    assign bus.rk_out    = rk_out_q;
    assign bus.rk_valid  = rk_valid_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Self-checking bench for aes_key_expand_seq: FIPS-197 vector table, multi-cycle
// corner sequences, and random keys against a FIPS-style schedule model.
module tb_aes_key_expand_seq;
    import aes_key_expand_seq_pkg::*;

    localparam logic [255:0] K128 = 256'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [255:0] K192 = 256'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7;
    localparam logic [255:0] K256 = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;

    logic clk;
    logic rst_n;

    aes_key_expand_seq_if #(.MAX_NK(8)) bus ();

    aes_key_expand_seq #(.MAX_NK(8), .MAX_NR(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  sbox_tab [256];
    logic [31:0] mw [MAX_WORDS];
    int          m_nk;
    int          m_nr;

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] len, input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        m_nk = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
        m_nr = m_nk + 6;
        for (int n = 0; n < m_nk; n++) mw[n] = k[n*32 +: 32];
        rc = 8'h01;
        for (int i = m_nk; i < 4 * (m_nr + 1); i++) begin
            t = mw[i-1];
            if (i % m_nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end else if (m_nk > 6 && i % m_nk == 4) begin
                t = sub_word(t);
            end
            mw[i] = mw[i-m_nk] ^ t;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic run_expand(input logic [1:0] len, input logic [255:0] k,
                              input int glitch_at, input string tag);
        int cyc;
        bit seen;
        int words;
        words = (len == 2'b00) ? 40 : (len == 2'b01) ? 46 : 52;
        @(negedge clk);
        bus.key_len = len;
        bus.key     = k;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check($sformatf("%s busy_after_start", tag), 128'(bus.busy), 128'd1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            if (cyc == glitch_at) begin
                bus.start   = 1'b1;
                bus.key_len = 2'b01;
                bus.key     = {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom};
            end else if (cyc == glitch_at + 1) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) seen = 1;
        end
        check($sformatf("%s done_latency", tag), 128'(cyc), 128'(words));
        check($sformatf("%s busy_at_done", tag), 128'(bus.busy), 128'd0);
        check($sformatf("%s key_ready_at_done", tag), 128'(bus.key_ready), 128'd1);
        @(posedge clk);
        #1;
        check($sformatf("%s done_one_cycle", tag), 128'(bus.done), 128'd0);
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] d, output logic v);
        @(negedge clk);
        bus.rk_idx = idx;
        @(posedge clk);
        #1;
        d = bus.rk_out;
        v = bus.rk_valid;
    endtask

    task automatic check_schedule(input string tag);
        logic [127:0] d;
        logic         v;
        for (int r = 0; r < 16; r++) begin
            read_rk(4'(r), d, v);
            if (r <= m_nr) begin
                check($sformatf("%s rk%0d_valid", tag, r), 128'(v), 128'd1);
                check($sformatf("%s rk%0d", tag, r), d, {mw[4*r+3], mw[4*r+2], mw[4*r+1], mw[4*r]});
            end else begin
                check($sformatf("%s rk%0d_valid", tag, r), 128'(v), 128'd0);
                check($sformatf("%s rk%0d_zero", tag, r), d, 128'd0);
            end
        end
    endtask

    // ---------------- FIPS-197 vector table ----------------
    typedef struct {
        logic [1:0]   len;
        logic [255:0] key;
        logic [3:0]   idx;
        int           sel;      // word within rk_out to compare; -1 = whole rk_out must be 0
        logic [31:0]  exp_word;
        logic         exp_valid;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [127:0] d;
        logic         v;
        logic [1:0]   cur_len;
        logic [255:0] cur_key;
        bit           have;
        logic [255:0] rk;

        checks   = 0;
        failures = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.key     = '0;
        bus.rk_idx  = '0;
`ifdef KEYEXP_DEC_ORDER_EN
        bus.rk_rev  = 1'b0;
`endif
        build_sbox();

        vecs[0] = '{2'b00, K128, 4'd10, 3,  32'hb6630ca6, 1'b1};
        vecs[1] = '{2'b00, K128, 4'd10, 0,  32'hd014f9a8, 1'b1};
        vecs[2] = '{2'b00, K128, 4'd0,  0,  32'h2b7e1516, 1'b1};
        vecs[3] = '{2'b00, K128, 4'd0,  3,  32'h09cf4f3c, 1'b1};
        vecs[4] = '{2'b01, K192, 4'd12, 3,  32'h01002202, 1'b1};
        vecs[5] = '{2'b01, K192, 4'd13, -1, 32'h00000000, 1'b0};
        vecs[6] = '{2'b10, K256, 4'd14, 3,  32'h706c631e, 1'b1};
        vecs[7] = '{2'b10, K256, 4'd15, -1, 32'h00000000, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",      128'(bus.busy),      128'd0);
        check("reset done",      128'(bus.done),      128'd0);
        check("reset err",       128'(bus.err),       128'd0);
        check("reset key_ready", 128'(bus.key_ready), 128'd0);
        check("reset rk_valid",  128'(bus.rk_valid),  128'd0);
        check("reset rk_out",    bus.rk_out,          128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_rk(4'd0, d, v);
        check("pre_expand rk_valid", 128'(v), 128'd0);

        // Table-driven FIPS vectors
        have    = 0;
        cur_len = 2'b00;
        cur_key = '0;
        for (int n = 0; n < 8; n++) begin
            if (!have || cur_len != vecs[n].len || cur_key != vecs[n].key) begin
                run_expand(vecs[n].len, vecs[n].key, -1, $sformatf("vec%0d", n));
                have    = 1;
                cur_len = vecs[n].len;
                cur_key = vecs[n].key;
            end
            read_rk(vecs[n].idx, d, v);
            check($sformatf("vec%0d rk_valid", n), 128'(v), 128'(vecs[n].exp_valid));
            if (vecs[n].sel < 0) check($sformatf("vec%0d rk_out_zero", n), d, 128'd0);
            else check($sformatf("vec%0d rk_word", n), 128'(d[vecs[n].sel*32 +: 32]), 128'(vecs[n].exp_word));
        end

        // Illegal key_len: err pulse, no busy, schedule invalidated
        @(negedge clk);
        bus.key_len = 2'b11;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("illegal err_high",      128'(bus.err),       128'd1);
        check("illegal busy",          128'(bus.busy),      128'd0);
        check("illegal key_ready",     128'(bus.key_ready), 128'd0);
        @(posedge clk);
        #1;
        check("illegal err_one_cycle", 128'(bus.err),       128'd0);
        check("illegal still_idle",    128'(bus.busy),      128'd0);
        read_rk(4'd0, d, v);
        check("illegal rk_valid", 128'(v), 128'd0);

        // start pulse with different key/key_len during EXPAND is ignored
        run_expand(2'b00, K128, 10, "glitch");
        model_expand(2'b00, K128);
        check_schedule("glitch");

        // Reads during expansion stay invalid
        @(negedge clk);
        bus.key_len = 2'b10;
        bus.key     = K256;
        bus.rk_idx  = 4'd0;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_expand rk_valid", 128'(bus.rk_valid), 128'd0);

        // Async reset mid-expansion (about cycle 20), then AES-128 restart
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy",      128'(bus.busy),      128'd0);
        check("midreset key_ready", 128'(bus.key_ready), 128'd0);
        check("midreset rk_valid",  128'(bus.rk_valid),  128'd0);
        #2;
        rst_n = 1'b1;
        run_expand(2'b00, K128, -1, "after_reset");
        read_rk(4'd10, d, v);
        check("after_reset w43", 128'(d[127:96]), 128'(32'hb6630ca6));
        check("after_reset valid", 128'(v), 128'd1);

`ifdef KEYEXP_DEC_ORDER_EN
        model_expand(2'b00, K128);
        @(negedge clk);
        bus.rk_rev = 1'b1;
        read_rk(4'd0, d, v);
        check("rev rk0_is_round10", d, {mw[43], mw[42], mw[41], mw[40]});
        check("rev valid", 128'(v), 128'd1);
        read_rk(4'd10, d, v);
        check("rev rk10_is_round0", d, {mw[3], mw[2], mw[1], mw[0]});
        read_rk(4'd11, d, v);
        check("rev rk11_invalid", 128'(v), 128'd0);
        @(negedge clk);
        bus.rk_rev = 1'b0;
`endif

        // Random keys, every length, full schedule against the model
        for (int len = 0; len < 3; len++) begin
            for (int rep = 0; rep < 2; rep++) begin
                rk = {$urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom};
                run_expand(2'(len), rk, -1, $sformatf("rand_l%0d_%0d", len, rep));
                model_expand(2'(len), rk);
                check_schedule($sformatf("rand_l%0d_%0d", len, rep));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
